// File: rtl/pio_seq_pkg.sv
// -----------------------------------------------------------------------------
// pio_seq_pkg
// Shared definitions for the PIO pattern sequencer: config register map,
// CTRL/STATUS bit positions and the sequencer FSM state type.
// -----------------------------------------------------------------------------
package pio_seq_pkg;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_PERIOD  = 2'd1;
    localparam logic [1:0] ADDR_PATTERN = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    localparam int CTRL_RUN_BIT   = 0;
    localparam int CTRL_LOOP_BIT  = 1;
    localparam int CTRL_CLEAR_BIT = 2;

    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_STEP_LSB = 4;
    localparam int STAT_OVF_BIT  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/pio_seq_table.sv
// -----------------------------------------------------------------------------
// pio_seq_table
// DEPTH x DATA_W pattern register file. Synchronous write, asynchronous read.
// Contents are deliberately not reset.
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write index
//   wdata  in   pattern to store
//   raddr  in   read index (sequencer step)
//   rdata  out  pattern at raddr
// -----------------------------------------------------------------------------
module pio_seq_table #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 4,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pio_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// pio_pattern_sequencer
// Plays a CPU-loaded table of LED patterns into PIO register 0, one write per
// dwell period, once or looping.
//   clk, reset                 clock, async active-high reset
//   address/chipselect/write_n/writedata/readdata
//                              config slave (CTRL, PERIOD, PATTERN, STATUS)
//   pio_address/pio_chipselect/pio_write_n/pio_writedata
//                              master side toward PIO s1 (no waitrequest)
//   busy                       high while the sequencer is not idle
//
// state | meaning
// IDLE  | waiting for RUN with a non-empty table
// ISSUE | one-cycle write strobe of table[step], dwell timer loaded
// WAIT  | dwell timer counting down to zero
// -----------------------------------------------------------------------------
module pio_pattern_sequencer
    import pio_seq_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int DATA_W   = 4,
    parameter int PERIOD_W = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata,
    output logic        busy
);

    localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // count must be able to hold DEPTH itself (table full)
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    seq_state_t state, state_nxt;

    logic                run, loop, ovf;
    logic [PERIOD_W-1:0] period, period_eff;
    logic [PERIOD_W-1:0] timer, timer_nxt;
    logic [CW-1:0]       count;
    logic [SW-1:0]       step, step_nxt;
    logic [DATA_W-1:0]   cur_pattern;

    logic cfg_wr, wr_ctrl, wr_period, wr_pattern, wr_status;
    logic idle, stop_req, seq_done, tbl_we, more_entries;

    assign cfg_wr     = chipselect & ~write_n;
    assign wr_ctrl    = cfg_wr & (address == ADDR_CTRL);
    assign wr_period  = cfg_wr & (address == ADDR_PERIOD);
    assign wr_pattern = cfg_wr & (address == ADDR_PATTERN);
    assign wr_status  = cfg_wr & (address == ADDR_STATUS);

    assign idle         = (state == IDLE);
    // Clearing RUN acts on the same edge as the write, not one cycle later.
    assign stop_req     = wr_ctrl & ~writedata[CTRL_RUN_BIT];
    assign tbl_we       = wr_pattern & idle & (count != COUNT_FULL);
    assign period_eff   = (period == '0) ? PERIOD_W'(1) : period;
    assign more_entries = (CW'(step) + CW'(1)) < count;

    pio_seq_table #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (SW)
    ) u_table (
        .clk   (clk),
        .we    (tbl_we),
        .waddr (count[SW-1:0]),
        .wdata (writedata[DATA_W-1:0]),
        .raddr (step),
        .rdata (cur_pattern)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            step  <= '0;
            timer <= '0;
        end else begin
            state <= state_nxt;
            step  <= step_nxt;
            timer <= timer_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        timer_nxt = timer;
        seq_done  = 1'b0;
        case (state)
            IDLE: begin
                if (run && (count != '0)) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                timer_nxt = period_eff - PERIOD_W'(1);
                state_nxt = WAIT;
            end
            WAIT: begin
                if (timer != '0) begin
                    timer_nxt = timer - PERIOD_W'(1);
                end else if (more_entries) begin
                    step_nxt  = step + SW'(1);
                    state_nxt = ISSUE;
                end else if (loop) begin
                    step_nxt  = '0;
                    state_nxt = ISSUE;
                end else begin
                    step_nxt  = '0;
                    seq_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (stop_req) begin
            state_nxt = IDLE;
            step_nxt  = '0;
            seq_done  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run    <= 1'b0;
            loop   <= 1'b0;
            period <= PERIOD_W'(1);
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            // A CPU write to CTRL wins over the end-of-sequence RUN clear.
            if (wr_ctrl) begin
                run  <= writedata[CTRL_RUN_BIT];
                loop <= writedata[CTRL_LOOP_BIT];
            end else if (seq_done) begin
                run <= 1'b0;
            end

            if (wr_period) begin
                period <= writedata[PERIOD_W-1:0];
            end

            if (wr_ctrl && writedata[CTRL_CLEAR_BIT] && idle) begin
                count <= '0;
            end else if (tbl_we) begin
                count <= count + CW'(1);
            end

            if (wr_status) begin
                ovf <= 1'b0;
            end else if (wr_pattern && idle && (count == COUNT_FULL)) begin
                ovf <= 1'b1;
            end
        end
    end

    assign busy           = ~idle;
    assign pio_address    = 2'b00;
    assign pio_chipselect = (state == ISSUE);
    assign pio_write_n    = ~pio_chipselect;
    // Gated so the bus is quiet (and never X from the unreset table) between strobes.
    assign pio_writedata  = pio_chipselect ? 32'(cur_pattern) : 32'd0;

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL: begin
                readdata[CTRL_RUN_BIT]  = run;
                readdata[CTRL_LOOP_BIT] = loop;
            end
            ADDR_PERIOD:  readdata = 32'(period);
            ADDR_PATTERN: readdata = 32'(count);
            default: begin
                readdata[STAT_BUSY_BIT]        = busy;
                readdata[STAT_STEP_LSB +: 4]   = 4'(step);
                readdata[STAT_OVF_BIT]         = ovf;
            end
        endcase
    end

endmodule

// File: tb/tb_pio_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pio_pattern_sequencer
// Directed bench for pio_pattern_sequencer. A schedule-level model predicts
// every cycle's PIO strobe/data and busy; directed tests pin timing and data
// with hand-computed literals and read back the config registers.
// -----------------------------------------------------------------------------
module tb_pio_pattern_sequencer;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic        busy;

    pio_pattern_sequencer #(
        .DEPTH    (8),
        .DATA_W   (4),
        .PERIOD_W (24)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .address        (address),
        .chipselect     (chipselect),
        .write_n        (write_n),
        .writedata      (writedata),
        .readdata       (readdata),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata),
        .busy           (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_assert = 0;
    int n_fail   = 0;
    int e        = 0;

    // observed strobes: edge number of the strobe cycle and its data
    int         s_cyc [$];
    logic [3:0] s_dat [$];

    // schedule-level model
    logic [3:0] m_tab [8];
    int  m_count = 0, m_period = 1, m_idx = 0, m_next = 0;
    bit  m_run = 0, m_loop = 0, m_ovf = 0, m_active = 0, m_strobe = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    always begin : model_b
        bit wr, stop, prev_strobe, end_run, old_run, old_loop, was_busy;
        int old_period, old_count, dwell;
        logic [38:0] got_v, exp_v;
        @(posedge clk);
        e = e + 1;
        if (reset) begin
            m_run = 0; m_loop = 0; m_period = 1; m_count = 0; m_ovf = 0;
            m_active = 0; m_idx = 0; m_strobe = 0; m_next = 0;
        end else begin
            wr          = chipselect && !write_n;
            stop        = wr && (address == 2'd0) && !writedata[0];
            prev_strobe = m_strobe;
            old_run     = m_run;
            old_loop    = m_loop;
            old_period  = m_period;
            old_count   = m_count;
            was_busy    = m_active;
            m_strobe    = 0;
            end_run     = 0;
            // each strobe is followed by max(PERIOD,1)+1 cycles to the next
            if (prev_strobe) begin
                dwell  = (old_period < 1) ? 1 : old_period;
                m_next = (e - 1) + dwell + 1;
            end
            if (m_active) begin
                if (e == m_next) begin
                    if (m_idx + 1 < old_count) begin
                        m_idx = m_idx + 1; m_strobe = 1;
                    end else if (old_loop) begin
                        m_idx = 0; m_strobe = 1;
                    end else begin
                        m_idx = 0; m_active = 0; end_run = 1;
                    end
                end
            end else if (old_run && old_count != 0) begin
                m_active = 1; m_idx = 0; m_strobe = 1;
            end
            if (stop) begin
                m_active = 0; m_idx = 0; m_strobe = 0; end_run = 0;
            end
            if (wr) begin
                case (address)
                    2'd0: begin
                        m_run  = writedata[0];
                        m_loop = writedata[1];
                        if (writedata[2] && !was_busy) m_count = 0;
                    end
                    2'd1: m_period = int'(writedata[23:0]);
                    2'd2: begin
                        if (!was_busy) begin
                            if (m_count < 8) begin
                                m_tab[m_count] = writedata[3:0];
                                m_count = m_count + 1;
                            end else begin
                                m_ovf = 1;
                            end
                        end
                    end
                    default: m_ovf = 0;
                endcase
            end
            if (end_run && !(wr && address == 2'd0)) m_run = 0;
        end
        #1;
        got_v = {busy, pio_chipselect, pio_write_n, pio_address, pio_writedata};
        exp_v = {m_active, m_strobe, !m_strobe, 2'b00,
                 m_strobe ? {28'd0, m_tab[m_idx]} : 32'd0};
        n_assert++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL cycle_outputs edge=%0d got=0x%0h exp=0x%0h", e, got_v, exp_v);
        end
        if (pio_chipselect === 1'b1 && pio_write_n === 1'b0) begin
            s_cyc.push_back(e);
            s_dat.push_back(pio_writedata[3:0]);
        end
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d, output int edge_no);
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        @(posedge clk);
        #1;
        edge_no = e;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        #1;
        chk(name, readdata, exp);
        chipselect = 1'b0;
    endtask

    task automatic wait_strobes(input int n, input int budget);
        for (int i = 0; i < budget && s_cyc.size() < n; i++) begin
            @(posedge clk);
            #2;
        end
        chk("strobe_timeout", s_cyc.size() >= n, 1);
    endtask

    initial begin
        int ew;
        int n0;
        logic [3:0] seq4 [4];
        seq4 = '{4'h1, 4'h2, 4'h4, 4'h8};
        reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        repeat (2) @(negedge clk);
        chk("reset_write_n", pio_write_n, 1);
        chk("reset_chipselect", pio_chipselect, 0);
        @(negedge clk);
        reset = 1'b0;

        // reset register values
        rd("rst_ctrl", 2'd0, 32'd0);
        rd("rst_period", 2'd1, 32'd1);
        rd("rst_pattern", 2'd2, 32'd0);
        rd("rst_status", 2'd3, 32'd0);

        // single pass 1,2,4,8 with PERIOD=3
        wr(2'd2, 32'h1, ew);
        wr(2'd2, 32'h2, ew);
        wr(2'd2, 32'h4, ew);
        wr(2'd2, 32'h8, ew);
        wr(2'd1, 32'd3, ew);
        s_cyc.delete(); s_dat.delete();
        wr(2'd0, 32'h1, ew);
        repeat (30) @(negedge clk);
        chk("once_num_strobes", s_cyc.size(), 4);
        if (s_cyc.size() == 4) begin
            chk("once_first_lat", s_cyc[0], ew + 1);
            for (int i = 0; i < 4; i++) chk("once_data", s_dat[i], seq4[i]);
            for (int i = 1; i < 4; i++) chk("once_gap", s_cyc[i] - s_cyc[i-1], 4);
        end
        rd("once_ctrl_after", 2'd0, 32'd0);
        rd("once_status_after", 2'd3, 32'd0);

        // looping run, then stop mid-dwell
        s_cyc.delete(); s_dat.delete();
        wr(2'd0, 32'h3, ew);
        wait_strobes(20, 200);
        if (s_cyc.size() >= 20) begin
            for (int i = 0; i < 20; i++) chk("loop_data", s_dat[i], seq4[i % 4]);
            chk("loop_gap", s_cyc[19] - s_cyc[0], 76);
        end
        @(negedge clk);
        wr(2'd0, 32'h0, ew);
        chk("stop_busy", busy, 0);
        n0 = s_cyc.size();
        repeat (20) @(negedge clk);
        chk("stop_no_more", s_cyc.size(), n0);
        rd("stop_status", 2'd3, 32'd0);

        // overflow and CLEAR
        wr(2'd0, 32'h4, ew);
        rd("clear_pattern", 2'd2, 32'd0);
        for (int i = 0; i < 9; i++) wr(2'd2, 32'(i), ew);
        rd("ovf_count", 2'd2, 32'd8);
        rd("ovf_status", 2'd3, 32'h100);
        wr(2'd3, 32'h0, ew);
        rd("ovf_cleared", 2'd3, 32'd0);
        wr(2'd0, 32'h4, ew);
        rd("clear_again", 2'd2, 32'd0);

        // RUN with empty table, then a late pattern write starts it
        s_cyc.delete(); s_dat.delete();
        wr(2'd0, 32'h1, ew);
        repeat (10) @(negedge clk);
        chk("empty_no_strobe", s_cyc.size(), 0);
        chk("empty_busy", busy, 0);
        rd("empty_run_held", 2'd0, 32'd1);
        wr(2'd2, 32'h5, ew);
        repeat (12) @(negedge clk);
        chk("late_num", s_cyc.size(), 1);
        if (s_cyc.size() == 1) begin
            chk("late_lat", s_cyc[0], ew + 1);
            chk("late_data", s_dat[0], 4'h5);
        end
        rd("late_run_done", 2'd0, 32'd0);

        // PERIOD=0 behaves as 1
        wr(2'd0, 32'h4, ew);
        wr(2'd1, 32'd0, ew);
        wr(2'd2, 32'hA, ew);
        wr(2'd2, 32'h3, ew);
        s_cyc.delete(); s_dat.delete();
        wr(2'd0, 32'h1, ew);
        repeat (10) @(negedge clk);
        chk("p0_num", s_cyc.size(), 2);
        if (s_cyc.size() == 2) begin
            chk("p0_first", s_cyc[0], ew + 1);
            chk("p0_second", s_cyc[1], ew + 3);
            chk("p0_data0", s_dat[0], 4'hA);
            chk("p0_data1", s_dat[1], 4'h3);
        end

        // async reset in the middle of a dwell
        s_cyc.delete(); s_dat.delete();
        wr(2'd0, 32'h3, ew);
        wait_strobes(1, 20);
        @(negedge clk);
        @(negedge clk);
        address = 2'd0;
        reset = 1'b1;
        #1;
        chk("async_reset_outputs",
            {busy, pio_chipselect, pio_write_n, pio_address, pio_writedata, readdata},
            {1'b0, 1'b0, 1'b1, 2'b00, 32'd0, 32'd0});
        @(negedge clk);
        reset = 1'b0;
        rd("post_rst_period", 2'd1, 32'd1);
        rd("post_rst_pattern", 2'd2, 32'd0);
        rd("post_rst_status", 2'd3, 32'd0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
